// File: rtl/fb_swap_ctrl.sv
// fb_swap_ctrl: double-buffer sequencer for the pixel framebuffer.
// Writes each complete incoming frame into the back bank and swaps the
// front/back banks only on a vblank pulse once a full frame is ready.
// Optional saturating statistics are built when FB_SWAP_STATS_EN is defined.
module fb_swap_ctrl #(
    parameter int DATA_WIDTH = 20,
    parameter int ADDR_WIDTH = 14,
    parameter int FB_DEPTH   = 16384
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_sof,
    output logic                  s_ready,
    input  logic                  vblank,
    output logic [DATA_WIDTH-1:0] fb_wdata,
    output logic [ADDR_WIDTH-1:0] fb_waddr,
    output logic                  fb_we,
    output logic                  fb_wbank,
    output logic                  selection,
    output logic                  swap,
    output logic                  resync,
    output logic [15:0]           frames_swapped,
    output logic [15:0]           vblank_repeats
);

    typedef enum logic [1:0] {
        ST_WAIT_SOF = 2'd0,
        ST_FILL     = 2'd1,
        ST_PENDING  = 2'd2
    } state_t;

    // Address of the final pixel in a frame; reaching it completes the frame.
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FB_DEPTH - 1);

    state_t                  state_q,     state_d;
    logic [ADDR_WIDTH-1:0]   count_q,     count_d;
    logic                    selection_q, selection_d;
    logic                    we_q,        we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q,     waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q,     wdata_d;
    logic                    wbank_q,     wbank_d;
    logic                    swap_q,      swap_d;
    logic                    resync_q,    resync_d;

    logic                    ready_s;
    logic                    accept_s;
    logic                    write_s;
    logic [ADDR_WIDTH-1:0]   wr_addr_s;
    logic                    swap_event_s;

    // Ready depends only on state so the upstream never sees a comb loop.
    always_comb begin
        ready_s = 1'b0;
        case (state_q)
            ST_WAIT_SOF: ready_s = 1'b1;
            ST_FILL:     ready_s = 1'b1;
            ST_PENDING:  ready_s = 1'b0;
            default:     ready_s = 1'b0;
        endcase
    end

    assign accept_s     = s_valid & ready_s;
    assign swap_event_s = (state_q == ST_PENDING) & vblank;

    // Next-state, write-port and bank-selection logic.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        selection_d = selection_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        wbank_d     = wbank_q;
        swap_d      = 1'b0;
        resync_d    = 1'b0;
        write_s     = 1'b0;
        wr_addr_s   = {ADDR_WIDTH{1'b0}};

        case (state_q)
            ST_WAIT_SOF: begin
                // Only a start-of-frame beat opens a frame; stray beats are dropped.
                if (accept_s && s_sof) begin
                    write_s   = 1'b1;
                    wr_addr_s = {ADDR_WIDTH{1'b0}};
                end else begin
                    write_s   = 1'b0;
                end
            end
            ST_FILL: begin
                if (accept_s) begin
                    write_s = 1'b1;
                    if (s_sof) begin
                        // New frame started early: abandon the partial one.
                        wr_addr_s = {ADDR_WIDTH{1'b0}};
                        resync_d  = 1'b1;
                    end else begin
                        wr_addr_s = count_q;
                    end
                end else begin
                    write_s = 1'b0;
                end
            end
            ST_PENDING: begin
                // A full frame waits here; vblank is the only safe swap point.
                if (vblank) begin
                    selection_d = ~selection_q;
                    swap_d      = 1'b1;
                    state_d     = ST_WAIT_SOF;
                end else begin
                    state_d     = ST_PENDING;
                end
            end
            default: begin
                state_d = ST_WAIT_SOF;
                count_d = {ADDR_WIDTH{1'b0}};
            end
        endcase

        // Shared write path: latch the beat and advance or close the frame.
        if (write_s) begin
            we_d    = 1'b1;
            waddr_d = wr_addr_s;
            wdata_d = s_data;
            wbank_d = ~selection_q;
            if (wr_addr_s == LAST_ADDR) begin
                state_d = ST_PENDING;
                count_d = {ADDR_WIDTH{1'b0}};
            end else begin
                state_d = ST_FILL;
                count_d = wr_addr_s + ADDR_WIDTH'(1);
            end
        end else begin
            we_d = 1'b0;
        end
    end

    // Registered state, write port and bank selection with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_WAIT_SOF;
            count_q     <= {ADDR_WIDTH{1'b0}};
            selection_q <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= {ADDR_WIDTH{1'b0}};
            wdata_q     <= {DATA_WIDTH{1'b0}};
            wbank_q     <= 1'b1;
            swap_q      <= 1'b0;
            resync_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            selection_q <= selection_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            wbank_q     <= wbank_d;
            swap_q      <= swap_d;
            resync_q    <= resync_d;
        end
    end

`ifdef FB_SWAP_STATS_EN
    logic [15:0] frames_q;
    logic [15:0] repeats_q;
    logic        repeat_event_s;

    assign repeat_event_s = vblank & ~swap_event_s;

    // Saturating counters of swaps and of vblanks that found no frame ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_q  <= 16'd0;
            repeats_q <= 16'd0;
        end else begin
            if (swap_event_s && (frames_q != 16'hFFFF)) begin
                frames_q <= frames_q + 16'd1;
            end else begin
                frames_q <= frames_q;
            end
            if (repeat_event_s && (repeats_q != 16'hFFFF)) begin
                repeats_q <= repeats_q + 16'd1;
            end else begin
                repeats_q <= repeats_q;
            end
        end
    end

    assign frames_swapped = frames_q;
    assign vblank_repeats = repeats_q;
`else
    assign frames_swapped = 16'd0;
    assign vblank_repeats = 16'd0;
`endif

    assign s_ready   = ready_s;
    assign fb_we     = we_q;
    assign fb_waddr  = waddr_q;
    assign fb_wdata  = wdata_q;
    assign fb_wbank  = wbank_q;
    assign selection = selection_q;
    assign swap      = swap_q;
    assign resync    = resync_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed table-driven bench for fb_swap_ctrl with a 4-pixel frame.
module tb_fb_swap_ctrl;

    localparam int DW = 20;
    localparam int AW = 14;
`ifdef FB_SWAP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_sof;
    logic          s_ready;
    logic          vblank;
    logic [DW-1:0] fb_wdata;
    logic [AW-1:0] fb_waddr;
    logic          fb_we;
    logic          fb_wbank;
    logic          selection;
    logic          swap;
    logic          resync;
    logic [15:0]   frames_swapped;
    logic [15:0]   vblank_repeats;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fb_swap_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FB_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
        .s_ready(s_ready), .vblank(vblank), .fb_wdata(fb_wdata), .fb_waddr(fb_waddr),
        .fb_we(fb_we), .fb_wbank(fb_wbank), .selection(selection), .swap(swap),
        .resync(resync), .frames_swapped(frames_swapped), .vblank_repeats(vblank_repeats)
    );

    typedef struct {
        logic          rst, v, sof, vb;
        logic [DW-1:0] d;
        logic          we;
        logic [AW-1:0] addr;
        logic          bank, sel, sw, rsy, rdy;
        logic [15:0]   fs, vr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic sf, input logic [DW-1:0] d,
                       input logic vb, input logic we, input logic [AW-1:0] a, input logic bk,
                       input logic sl, input logic sw, input logic rs, input logic rd,
                       input logic [15:0] fs, input logic [15:0] vr);
        vec_t x;
        x.rst = r; x.v = v; x.sof = sf; x.d = d; x.vb = vb; x.we = we; x.addr = a;
        x.bank = bk; x.sel = sl; x.sw = sw; x.rsy = rs; x.rdy = rd; x.fs = fs; x.vr = vr;
        vecs.push_back(x);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic sf,
                         input logic [DW-1:0] d, input logic vb);
        @(negedge clk);
        rst = r; s_valid = v; s_sof = sf; s_data = d; vblank = vb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; vblank = 1'b0;

        // Reset followed by ten idle cycles.
        drive(1'b1, 1'b0, 1'b0, 20'h00000, 1'b0);
        check("rst_waddr", -1, 32'(fb_waddr), 32'd0);
        check("rst_wdata", -1, 32'(fb_wdata), 32'd0);
        check("rst_wbank", -1, 32'(fb_wbank), 32'd1);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 20'h00000, 1'b0);
            check("idle_sel",   i, 32'(selection), 32'd0);
            check("idle_wbank", i, 32'(fb_wbank),  32'd1);
            check("idle_rdy",   i, 32'(s_ready),   32'd1);
            check("idle_we",    i, 32'(fb_we),     32'd0);
        end

        //   rst   v     sof   data       vb  | we   addr   bank  sel   swap  rsy   rdy   fs      vr
        // stray beats in WAIT_SOF are dropped
        add(1'b0,1'b1,1'b0,20'h00011,1'b0, 1'b0,14'd0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0,16'd0);
        add(1'b0,1'b1,1'b0,20'h00012,1'b0, 1'b0,14'd0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0,16'd0);
        add(1'b0,1'b1,1'b0,20'h00013,1'b0, 1'b0,14'd0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0,16'd0);
        // frame 1 into bank 1
        add(1'b0,1'b1,1'b1,20'hA0001,1'b0, 1'b1,14'd0,1'b1,1'b0,1'b0,1'b0,1'b1,16'd0,16'd0);
        add(1'b0,1'b1,1'b0,20'hA0002,1'b0, 1'b1,14'd1,1'b1,1'b0,1'b0,1'b0,1'b1,16'd0,16'd0);
        add(1'b0,1'b1,1'b0,20'hA0003,1'b0, 1'b1,14'd2,1'b1,1'b0,1'b0,1'b0,1'b1,16'd0,16'd0);
        add(1'b0,1'b1,1'b0,20'hA0004,1'b0, 1'b1,14'd3,1'b1,1'b0,1'b0,1'b0,1'b0,16'd0,16'd0);
        // PENDING refuses beats, then vblank swaps
        add(1'b0,1'b1,1'b1,20'hEEEEE,1'b0, 1'b0,14'd0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,16'd0);
        add(1'b0,1'b0,1'b0,20'h00000,1'b0, 1'b0,14'd0,1'b0,1'b0,1'b0,1'b0,1'b0,16'd0,16'd0);
        add(1'b0,1'b0,1'b0,20'h00000,1'b1, 1'b0,14'd0,1'b0,1'b1,1'b1,1'b0,1'b1,16'd1,16'd0);
        add(1'b0,1'b0,1'b0,20'h00000,1'b0, 1'b0,14'd0,1'b0,1'b1,1'b0,1'b0,1'b1,16'd1,16'd0);
        // frame 2 into bank 0, restarted mid-frame; vblanks in FILL ignored
        add(1'b0,1'b1,1'b1,20'hB0001,1'b0, 1'b1,14'd0,1'b0,1'b1,1'b0,1'b0,1'b1,16'd1,16'd0);
        add(1'b0,1'b1,1'b0,20'hB0002,1'b1, 1'b1,14'd1,1'b0,1'b1,1'b0,1'b0,1'b1,16'd1,16'd1);
        add(1'b0,1'b1,1'b1,20'hC0001,1'b0, 1'b1,14'd0,1'b0,1'b1,1'b0,1'b1,1'b1,16'd1,16'd1);
        add(1'b0,1'b1,1'b0,20'hC0002,1'b0, 1'b1,14'd1,1'b0,1'b1,1'b0,1'b0,1'b1,16'd1,16'd1);
        add(1'b0,1'b1,1'b0,20'hC0003,1'b0, 1'b1,14'd2,1'b0,1'b1,1'b0,1'b0,1'b1,16'd1,16'd1);
        add(1'b0,1'b1,1'b0,20'hC0004,1'b1, 1'b1,14'd3,1'b0,1'b1,1'b0,1'b0,1'b0,16'd1,16'd2);
        add(1'b0,1'b0,1'b0,20'h00000,1'b1, 1'b0,14'd0,1'b0,1'b0,1'b1,1'b0,1'b1,16'd2,16'd2);
        // vblank in WAIT_SOF is a repeat
        add(1'b0,1'b0,1'b0,20'h00000,1'b1, 1'b0,14'd0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd2,16'd3);
        // frame 3 into bank 1, swap to selection 1
        add(1'b0,1'b1,1'b1,20'hD0001,1'b0, 1'b1,14'd0,1'b1,1'b0,1'b0,1'b0,1'b1,16'd2,16'd3);
        add(1'b0,1'b1,1'b0,20'hD0002,1'b0, 1'b1,14'd1,1'b1,1'b0,1'b0,1'b0,1'b1,16'd2,16'd3);
        add(1'b0,1'b1,1'b0,20'hD0003,1'b0, 1'b1,14'd2,1'b1,1'b0,1'b0,1'b0,1'b1,16'd2,16'd3);
        add(1'b0,1'b1,1'b0,20'hD0004,1'b0, 1'b1,14'd3,1'b1,1'b0,1'b0,1'b0,1'b0,16'd2,16'd3);
        add(1'b0,1'b0,1'b0,20'h00000,1'b1, 1'b0,14'd0,1'b0,1'b1,1'b1,1'b0,1'b1,16'd3,16'd3);
        // frame 4 into bank 0, reaches PENDING with selection 1
        add(1'b0,1'b1,1'b1,20'hE0001,1'b0, 1'b1,14'd0,1'b0,1'b1,1'b0,1'b0,1'b1,16'd3,16'd3);
        add(1'b0,1'b1,1'b0,20'hE0002,1'b0, 1'b1,14'd1,1'b0,1'b1,1'b0,1'b0,1'b1,16'd3,16'd3);
        add(1'b0,1'b1,1'b0,20'hE0003,1'b0, 1'b1,14'd2,1'b0,1'b1,1'b0,1'b0,1'b1,16'd3,16'd3);
        add(1'b0,1'b1,1'b0,20'hE0004,1'b0, 1'b1,14'd3,1'b0,1'b1,1'b0,1'b0,1'b0,16'd3,16'd3);
        // reset in PENDING beats a concurrent vblank
        add(1'b1,1'b0,1'b0,20'h00000,1'b1, 1'b0,14'd0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0,16'd0);
        add(1'b0,1'b0,1'b0,20'h00000,1'b0, 1'b0,14'd0,1'b0,1'b0,1'b0,1'b0,1'b1,16'd0,16'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v, vecs[i].sof, vecs[i].d, vecs[i].vb);
            check("we",     i, 32'(fb_we),     32'(vecs[i].we));
            check("sel",    i, 32'(selection), 32'(vecs[i].sel));
            check("swap",   i, 32'(swap),      32'(vecs[i].sw));
            check("resync", i, 32'(resync),    32'(vecs[i].rsy));
            check("ready",  i, 32'(s_ready),   32'(vecs[i].rdy));
            check("frames", i, 32'(frames_swapped), STATS ? 32'(vecs[i].fs) : 32'd0);
            check("repeats",i, 32'(vblank_repeats), STATS ? 32'(vecs[i].vr) : 32'd0);
            if (vecs[i].we) begin
                check("waddr", i, 32'(fb_waddr), 32'(vecs[i].addr));
                check("wdata", i, 32'(fb_wdata), 32'(vecs[i].d));
                check("wbank", i, 32'(fb_wbank), 32'(vecs[i].bank));
            end
        end

        // After the PENDING reset the write port is back to its reset values.
        check("post_rst_waddr", -2, 32'(fb_waddr), 32'd0);
        check("post_rst_wdata", -2, 32'(fb_wdata), 32'd0);
        check("post_rst_wbank", -2, 32'(fb_wbank), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
